multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL provide: inst  in  32  current instruction register contents; only inst[6:0] is decoded.
REQ-004 SHALL provide: zero  in  1  ALU zero flag, valid in EXEC.
REQ-005 SHALL provide: mem_ready  in  1  memory completes the current access this cycle.
REQ-006 SHALL provide: mem_req, mem_we, i_or_d (0 = PC address, 1 = ALU address)  out  1 each.
REQ-007 SHALL provide: ir_we, pc_we, pc_src (0 = PC+4, 1 = branch target)  out  1 each.
REQ-008 SHALL provide: alu_src, reg_write, mem_to_reg  out  1 each; alu_op  out  2.
REQ-009 SHALL provide: illegal  out  1  sticky trap flag; state  out  3  current state encoding.
REQ-010 SHALL provide: retired  out  32  count of completed instructions.

Function
REQ-011 SHALL implement states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5; encodings 6 and 7 SHALL go to FETCH.
REQ-012 SHALL drive all outputs combinationally from state and inst[6:0]; every strobe not listed for a state SHALL be 0.
REQ-013 SHALL decode opcodes as: 0000011 lw, 0100011 sw, 1100011 beq, 0110011 R-type, 0010011 I-type; any other opcode is illegal.
REQ-014 FETCH SHALL assert mem_req = 1 with i_or_d = 0 and mem_we = 0, and SHALL hold until mem_ready = 1.
REQ-015 In the FETCH cycle where mem_ready = 1, the block SHALL pulse ir_we = 1 and pc_we = 1 with pc_src = 0, then go to DECODE.
REQ-016 DECODE SHALL assert no strobes; it SHALL go to EXEC for a legal opcode and to TRAP otherwise.
REQ-017 EXEC SHALL drive alu_op = 00 with alu_src = 1 for lw/sw, 01 with alu_src = 0 for beq, 10 with alu_src = 0 for R-type, and 11 with alu_src = 1 for I-type.
REQ-018 EXEC next state SHALL be MEM for lw/sw, WB for R-type/I-type, and FETCH for beq.
REQ-019 EXEC with beq and zero = 1 SHALL assert pc_we = 1 and pc_src = 1; with zero = 0, pc_we SHALL be 0.
REQ-020 MEM SHALL assert mem_req = 1, i_or_d = 1, alu_op = 00, alu_src = 1, and mem_we = 1 for sw only; it SHALL hold until mem_ready = 1.
REQ-021 On mem_ready in MEM, the block SHALL go to WB for lw and to FETCH for sw.
REQ-022 WB SHALL assert reg_write = 1 for one cycle, with mem_to_reg = 1 for lw and 0 otherwise; for R-type/I-type it SHALL hold the EXEC alu_op and alu_src values; next state SHALL be FETCH.
REQ-023 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-024 Zero-wait latency SHALL be beq 3, R-type/I-type/sw 4, lw 5 cycles, and each cycle of mem_ready = 0 SHALL add one cycle.
REQ-025 retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 TRAP SHALL be absorbing: illegal = 1, all strobes 0, retired frozen; only rst exits TRAP.

Reset
REQ-027 While rst = 1, all strobes and illegal SHALL be forced to 0, including mid-instruction and mid-wait.
REQ-028 After the reset edge, state SHALL be FETCH, retired SHALL be 0, and illegal SHALL be 0.
REQ-029 rst SHALL take priority over every transition; a reset asserted in the same cycle as mem_ready SHALL commit no ir_we or pc_we.

Verification
REQ-030 Bench SHALL cover: add (0x002081B3) with mem_ready held at 1 -> states 0,1,2,4,0; reg_write = 1 in cycle 4 only; retired = 1.
REQ-031 Bench SHALL cover: lw (0x0000A103) with mem_ready = 0 for 2 MEM cycles -> MEM lasts 3 cycles, WB shows mem_to_reg = 1, total 7 cycles.
REQ-032 Bench SHALL cover: beq with zero = 1 -> EXEC shows pc_we = 1 and pc_src = 1; with zero = 0 -> pc_we = 0; both complete in 3 cycles.
REQ-033 Bench SHALL cover: opcode 0x7F -> DECODE then TRAP, illegal = 1 and held for 20 cycles; rst restores FETCH with illegal = 0.
REQ-034 Bench SHALL cover: sw -> MEM shows mem_we = 1 and i_or_d = 1, no WB state, reg_write never set.
REQ-035 Bench SHALL cover: rst asserted in MEM during a wait -> strobes 0 in the reset cycle, then FETCH with retired = 0; retired preloaded via 2^32 - 1 completions wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: fetch/decode/exec/mem/wb sequencing,
// combinational strobes from state + opcode, sticky trap and retire counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;

  logic [6:0] opc;
  logic       is_lw, is_sw, is_beq, is_r, is_i, legal;
  logic       unused_inst;

  logic       mem_req_c, mem_we_c, i_or_d_c, ir_we_c, pc_we_c, pc_src_c;
  logic       alu_src_c, reg_write_c, mem_to_reg_c, illegal_c, retire;
  logic [1:0] alu_op_c;

  assign opc         = inst[6:0];
  assign unused_inst = ^inst[31:7];
  assign is_lw       = (opc == 7'b0000011);
  assign is_sw       = (opc == 7'b0100011);
  assign is_beq      = (opc == 7'b1100011);
  assign is_r        = (opc == 7'b0110011);
  assign is_i        = (opc == 7'b0010011);
  assign legal       = is_lw | is_sw | is_beq | is_r | is_i;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    i_or_d_c     = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 1'b0;
    alu_src_c    = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_op_c     = 2'b00;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        // ALU control is a pure function of the opcode class
        alu_op_c  = {is_r | is_i, is_beq | is_i};
        alu_src_c = is_lw | is_sw | is_i;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end else if (is_beq) begin
          pc_we_c  = zero;
          pc_src_c = zero;
          state_d  = S_FETCH;
          retire   = 1'b1;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        i_or_d_c  = 1'b1;
        alu_src_c = 1'b1;
        mem_we_c  = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
          retire  = !is_lw;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_lw;
        alu_op_c     = {is_r | is_i, is_i};
        alu_src_c    = is_i;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_TRAP: illegal_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset masks every control output so nothing commits mid-access.
  assign mem_req    = mem_req_c    & ~rst;
  assign mem_we     = mem_we_c     & ~rst;
  assign i_or_d     = i_or_d_c     & ~rst;
  assign ir_we      = ir_we_c      & ~rst;
  assign pc_we      = pc_we_c      & ~rst;
  assign pc_src     = pc_src_c     & ~rst;
  assign alu_src    = alu_src_c    & ~rst;
  assign reg_write  = reg_write_c  & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign alu_op     = alu_op_c     & {2{~rst}};
  assign illegal    = illegal_c    & ~rst;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule
